// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retire trace buffer: event type codes and the packed entry layout.
package retire_trace_buffer_pkg;

  localparam logic TRACE_GRF = 1'b0;
  localparam logic TRACE_DM  = 1'b1;

  localparam int TYPE_W   = 1;
  localparam int PC_W     = 32;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BYTEEN_W = 4;
  localparam int ENTRY_W  = TYPE_W + PC_W + ADDR_W + DATA_W + BYTEEN_W;

  typedef struct packed {
    logic                typ;
    logic [PC_W-1:0]     pc;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [BYTEEN_W-1:0] byteen;
  } trace_entry_t;

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// Show-ahead FIFO with two ordered write ports (port 0 lands first) and one read port.
module retire_trace_buffer_fifo
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we0,
  input  trace_entry_t           wd0,
  input  logic                   we1,
  input  trace_entry_t           wd1,
  input  logic                   re,
  output trace_entry_t           rd,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  trace_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            deq;

  assign deq   = re && (count_q != '0);
  assign count = count_q;
  // Entries are not reset; an empty FIFO presents an all-zero head instead.
  assign rd    = (count_q != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset && we0) mem[wr_ptr] <= wd0;
    if (reset && we1) mem[wr_ptr + PW'(1)] <= wd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(we0) + PW'(we1);
      rd_ptr  <= rd_ptr + PW'(deq);
      count_q <= count_q + CW'(we0) + CW'(we1) - CW'(deq);
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures W-stage GRF writes and M-stage DM stores, in program order, into a show-ahead trace FIFO.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit FILTER_R0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w_we,
  input  logic [31:0]            w_pc,
  input  logic [4:0]             w_addr,
  input  logic [31:0]            w_data,
  input  logic [3:0]             m_byteen,
  input  logic [31:0]            m_pc,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_type,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
  output logic [3:0]             out_byteen,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: out_valid is high whenever the FIFO holds an entry and out_* show that head;
  // a transfer happens on a rising edge where out_valid & out_ready, and out_ready alone does nothing.

  logic          grf_ev, dm_ev;
  logic          grf_acc, dm_acc;
  logic [CW-1:0] free;
  trace_entry_t  grf_entry, dm_entry, slot0, head;
  logic          overflow_q;

  assign grf_ev = w_we && !(FILTER_R0 && (w_addr == 5'd0));
  assign dm_ev  = |m_byteen;

  // Space is judged on the registered count only; a same-cycle pop does not free a slot.
  assign free    = CW'(DEPTH) - count;
  assign grf_acc = grf_ev && (free != '0);
  assign dm_acc  = dm_ev && (free > CW'(grf_acc));

  assign grf_entry = '{typ: TRACE_GRF, pc: w_pc, addr: {27'b0, w_addr}, data: w_data, byteen: 4'hF};
  assign dm_entry  = '{typ: TRACE_DM, pc: m_pc, addr: m_addr, data: m_data, byteen: m_byteen};

  // The older W event always takes the first slot; a lone DM event is compacted into it.
  assign slot0 = grf_acc ? grf_entry : dm_entry;

  retire_trace_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .we0   (grf_acc || dm_acc),
    .wd0   (slot0),
    .we1   (grf_acc && dm_acc),
    .wd1   (dm_entry),
    .re    (out_ready),
    .rd    (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if ((grf_ev && !grf_acc) || (dm_ev && !dm_acc)) begin
      overflow_q <= 1'b1;
    end
  end

  assign out_valid   = (count != '0);
  assign out_type    = head.typ;
  assign out_pc      = head.pc;
  assign out_addr    = head.addr;
  assign out_data    = head.data;
  assign out_byteen  = head.byteen;
  assign almost_full = (count >= CW'(DEPTH - 2));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_retire_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = 101;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_we;
  logic [31:0]   w_pc;
  logic [4:0]    w_addr;
  logic [31:0]   w_data;
  logic [3:0]    m_byteen;
  logic [31:0]   m_pc;
  logic [31:0]   m_addr;
  logic [31:0]   m_data;
  logic          out_ready;

  logic          out_valid, out_type, almost_full, overflow;
  logic [31:0]   out_pc, out_addr, out_data;
  logic [3:0]    out_byteen;
  logic [CW-1:0] count;

  logic          z_valid, z_type, z_af, z_ovf;
  logic [31:0]   z_pc, z_addr, z_data;
  logic [3:0]    z_byteen;
  logic [CW-1:0] z_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .FILTER_R0(1'b1)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_pc(w_pc), .w_addr(w_addr), .w_data(w_data),
    .m_byteen(m_byteen), .m_pc(m_pc), .m_addr(m_addr), .m_data(m_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_byteen(out_byteen),
    .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  retire_trace_buffer #(.DEPTH(DEPTH), .FILTER_R0(1'b0)) dut_nofilt (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_pc(w_pc), .w_addr(w_addr), .w_data(w_data),
    .m_byteen(m_byteen), .m_pc(m_pc), .m_addr(m_addr), .m_data(m_data),
    .out_valid(z_valid), .out_ready(out_ready), .out_type(z_type),
    .out_pc(z_pc), .out_addr(z_addr), .out_data(z_data), .out_byteen(z_byteen),
    .count(z_count), .almost_full(z_af), .overflow(z_ovf)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare the DUT against the model's view of the queue (called away from the clock edge).
  task automatic check_model();
    check("valid", 128'(out_valid), 128'(exp_q.size() != 0));
    check("count", 128'(count), 128'(exp_q.size()));
    check("almost_full", 128'(almost_full), 128'(exp_q.size() >= DEPTH - 2));
    check("overflow", 128'(overflow), 128'(exp_ovf));
    if (exp_q.size() != 0)
      check("head", 128'({out_type, out_pc, out_addr, out_data, out_byteen}), 128'(exp_q[0]));
  endtask

  // Reference behaviour: events are offered oldest first; each takes a slot if one is free
  // (free measured before this cycle's pop), otherwise it is lost and overflow latches.
  task automatic model_edge();
    int free;
    logic [W-1:0] ev[$];
    if (!reset) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      return;
    end
    free = DEPTH - exp_q.size();
    if (w_we && w_addr != 5'd0) ev.push_back({1'b0, w_pc, 27'd0, w_addr, w_data, 4'hF});
    if (m_byteen != 4'd0)       ev.push_back({1'b1, m_pc, m_addr, m_data, m_byteen});
    if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    foreach (ev[i]) begin
      if (free > 0) begin
        exp_q.push_back(ev[i]);
        free--;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic rdy);
    w_we = 1'b0; w_pc = '0; w_addr = '0; w_data = '0;
    m_byteen = '0; m_pc = '0; m_addr = '0; m_data = '0;
    out_ready = rdy;
  endtask

  task automatic grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    w_we = 1'b1; w_pc = pc; w_addr = a; w_data = d;
  endtask

  task automatic dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_byteen = be; m_pc = pc; m_addr = a; m_data = d;
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_ovf = 1'b0;
    reset = 1'b0;
    idle(1'b0);
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_af", 128'(almost_full), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_head", 128'({out_type, out_pc, out_addr, out_data, out_byteen}), 128'(0));

    // 1: single GRF event, visible the cycle after it is sampled
    grf(32'h3000, 5'd8, 32'h1234);
    cycle();
    idle(1'b0);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_type", 128'(out_type), 128'(0));
    check("t1_addr", 128'(out_addr), 128'(8));
    check("t1_data", 128'(out_data), 128'(32'h1234));
    check("t1_byteen", 128'(out_byteen), 128'(4'hF));
    check("t1_count", 128'(count), 128'(1));
    idle(1'b1);
    cycle();

    // 2: same-cycle GRF + DM, popped in program order
    grf(32'h3004, 5'd9, 32'hAAAA_0009);
    dm(32'h3008, 32'h10, 32'h0000_BEEF, 4'b0011);
    out_ready = 1'b1;
    cycle();
    idle(1'b1);
    check("t2_count2", 128'(count), 128'(2));
    check("t2_first", 128'(out_pc), 128'(32'h3004));
    cycle();
    check("t2_count1", 128'(count), 128'(1));
    check("t2_second", 128'(out_pc), 128'(32'h3008));
    cycle();
    check("t2_count0", 128'(count), 128'(0));

    // 3: writes to $0 are dropped only when filtering
    idle(1'b0);
    grf(32'h300C, 5'd0, 32'h5555);
    cycle();
    idle(1'b0);
    check("t3_filt_count", 128'(count), 128'(0));
    check("t3_nofilt_count", 128'(z_count), 128'(1));
    check("t3_nofilt_addr", 128'(z_addr), 128'(0));
    idle(1'b1);
    cycle();

    // 4: fill to DEPTH, then one more event is lost
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b0);
      grf(32'h4000 + 32'(i * 4), 5'(i + 1), 32'(i));
      cycle();
      check("t4_af", 128'(almost_full), 128'(i + 1 >= DEPTH - 2));
    end
    grf(32'h5000, 5'd3, 32'hDEAD);
    cycle();
    idle(1'b0);
    check("t4_count", 128'(count), 128'(DEPTH));
    check("t4_ovf", 128'(overflow), 128'(1));
    check("t4_head", 128'(out_pc), 128'(32'h4000));

    // 5: one free slot with a pair -> GRF kept, DM lost
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) begin
      idle(1'b0);
      grf(32'h6000 + 32'(i * 4), 5'd1, 32'(i));
      cycle();
    end
    idle(1'b0);
    check("t5_ovf_before", 128'(overflow), 128'(0));
    grf(32'h7000, 5'd2, 32'h7777);
    dm(32'h7004, 32'h20, 32'h8888, 4'b1111);
    cycle();
    idle(1'b0);
    check("t5_count", 128'(count), 128'(DEPTH));
    check("t5_ovf", 128'(overflow), 128'(1));
    idle(1'b1);
    for (int i = 0; i < DEPTH - 5; i++) cycle();
    idle(1'b0);
    check("t5_drained", 128'(count), 128'(5));

    // 6: reset with an event present clears everything, next event is accepted
    reset = 1'b0;
    grf(32'h8000, 5'd4, 32'h4444);
    cycle();
    reset = 1'b1;
    idle(1'b0);
    check("t6_count", 128'(count), 128'(0));
    check("t6_valid", 128'(out_valid), 128'(0));
    check("t6_ovf", 128'(overflow), 128'(0));
    grf(32'h8004, 5'd5, 32'h5050);
    cycle();
    idle(1'b0);
    check("t6_next", 128'(out_pc), 128'(32'h8004));
    cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) != 0);
      w_we      = ($urandom_range(0, 2) != 0);
      w_pc      = $urandom();
      w_addr    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
      w_data    = $urandom();
      m_byteen  = ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'd0;
      m_pc      = $urandom();
      m_addr    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      m_data    = $urandom();
      out_ready = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 30 : 80));
      cycle();
    end
    reset = 1'b1;
    idle(1'b1);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
